// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// fb_pkg : shared framebuffer types and default dimensions
// Rev 1.0
// ============================================================================
package fb_pkg;

  localparam int FB_DEF_WIDTH  = 160;
  localparam int FB_DEF_HEIGHT = 120;

  typedef enum logic [0:0] {
    FB_IDLE  = 1'b0,
    FB_CLEAR = 1'b1
  } fb_state_t;

  function automatic int fb_pixel_count(input int width, input int height);
    return width * height;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_addr_calc.sv
`default_nettype none
// ============================================================================
// fb_addr_calc : linear address (y*FB_WIDTH+x) and bounds check, combinational
// Rev 1.0
// ============================================================================
module fb_addr_calc #(
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120,
  parameter int CORDW     = 16,
  parameter int ADDRW     = 15
) (
  input  logic [CORDW-1:0] x,
  input  logic [CORDW-1:0] y,
  output logic [ADDRW-1:0] addr,
  output logic             in_bounds
);

  localparam logic [CORDW-1:0] WIDTH_C  = CORDW'(FB_WIDTH);
  localparam logic [CORDW-1:0] HEIGHT_C = CORDW'(FB_HEIGHT);
  localparam logic [ADDRW-1:0] STRIDE_C = ADDRW'(FB_WIDTH);

  // In-range coordinates always fit ADDRW, so narrowing before the multiply is lossless
  assign in_bounds = (x < WIDTH_C) && (y < HEIGHT_C);
  assign addr      = (ADDRW'(y) * STRIDE_C) + ADDRW'(x);

endmodule
`default_nettype wire

// File: rtl/fb_writer.sv
`default_nettype none
// ============================================================================
// fb_writer : framebuffer write controller (pixel writes and full-screen clear)
// Rev 1.0
// ============================================================================
module fb_writer
  import fb_pkg::*;
#(
  parameter int FB_WIDTH  = FB_DEF_WIDTH,
  parameter int FB_HEIGHT = FB_DEF_HEIGHT,
  parameter int CORDW     = 16,
  parameter int COLRW     = 4,
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT,
  localparam int ADDRW     = $clog2(FB_PIXELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [COLRW-1:0] clear_colr,
  output logic             busy,
  input  logic             px_valid,
  output logic             px_ready,
  input  logic [CORDW-1:0] px_x,
  input  logic [CORDW-1:0] px_y,
  input  logic [COLRW-1:0] px_colr,
  output logic             px_oob,
  output logic             bram_we,
  output logic [ADDRW-1:0] bram_addr,
  output logic [COLRW-1:0] bram_data
);

  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(FB_PIXELS - 1);

  fb_state_t        state;
  logic [ADDRW-1:0] cnt;
  logic [COLRW-1:0] fill_colr;
  logic [ADDRW-1:0] px_addr;
  logic             px_in_bounds;
  logic             px_accept;

  fb_addr_calc #(
    .FB_WIDTH  (FB_WIDTH),
    .FB_HEIGHT (FB_HEIGHT),
    .CORDW     (CORDW),
    .ADDRW     (ADDRW)
  ) u_addr_calc (
    .x         (px_x),
    .y         (px_y),
    .addr      (px_addr),
    .in_bounds (px_in_bounds)
  );

  assign px_ready  = (state == FB_IDLE) && !clear && !rst;
  assign px_accept = px_valid && px_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FB_IDLE;
      cnt       <= '0;
      fill_colr <= '0;
      busy      <= 1'b0;
      px_oob    <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_data <= '0;
    end else begin
      case (state)
        FB_IDLE: begin
          bram_we <= 1'b0;
          px_oob  <= 1'b0;
          busy    <= 1'b0;
          if (clear) begin
            // First clear write is issued here so it appears the cycle after the request
            state     <= FB_CLEAR;
            fill_colr <= clear_colr;
            cnt       <= '0;
            busy      <= 1'b1;
            bram_we   <= 1'b1;
            bram_addr <= '0;
            bram_data <= clear_colr;
          end else if (px_accept) begin
            if (px_in_bounds) begin
              bram_we   <= 1'b1;
              bram_addr <= px_addr;
              bram_data <= px_colr;
            end else begin
              px_oob <= 1'b1;
            end
          end
        end

        FB_CLEAR: begin
          // cnt tracks the address currently on the port
          if (cnt == LAST_ADDR) begin
            state   <= FB_IDLE;
            busy    <= 1'b0;
            bram_we <= 1'b0;
          end else begin
            cnt       <= cnt + 1'b1;
            busy      <= 1'b1;
            bram_we   <= 1'b1;
            bram_addr <= cnt + 1'b1;
            bram_data <= fill_colr;
          end
        end

        default: begin
          state   <= FB_IDLE;
          busy    <= 1'b0;
          bram_we <= 1'b0;
          px_oob  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_writer.sv
`default_nettype none
// ============================================================================
// tb_fb_writer : scoreboard bench for fb_writer (pixel path, clear, reset abort)
// Rev 1.0
// ============================================================================
module tb_fb_writer;

  localparam int W     = 160;
  localparam int H     = 120;
  localparam int CORDW = 16;
  localparam int COLRW = 4;
  localparam int NPIX  = W * H;
  localparam int ADDRW = $clog2(NPIX);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic [COLRW-1:0] clear_colr = '0;
  logic             busy;
  logic             px_valid = 1'b0;
  logic             px_ready;
  logic [CORDW-1:0] px_x = '0;
  logic [CORDW-1:0] px_y = '0;
  logic [COLRW-1:0] px_colr = '0;
  logic             px_oob;
  logic             bram_we;
  logic [ADDRW-1:0] bram_addr;
  logic [COLRW-1:0] bram_data;

  fb_writer #(
    .FB_WIDTH  (W),
    .FB_HEIGHT (H),
    .CORDW     (CORDW),
    .COLRW     (COLRW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .clear_colr (clear_colr),
    .busy       (busy),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .px_x       (px_x),
    .px_y       (px_y),
    .px_colr    (px_colr),
    .px_oob     (px_oob),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_data  (bram_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             oob;
    logic [ADDRW-1:0] addr;
    logic [COLRW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Every write or oob pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (bram_we === 1'b1 || px_oob === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {30'd0, bram_we, px_oob}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_oob", {31'd0, px_oob}, {31'd0, e.oob});
        check("sb_we", {31'd0, bram_we}, {31'd0, !e.oob});
        if (!e.oob) begin
          check("sb_addr", 32'(bram_addr), 32'(e.addr));
          check("sb_data", 32'(bram_data), 32'(e.data));
        end
      end
    end
  end

  task automatic push_px(input int x, input int y, input int c);
    exp_t e;
    e.oob  = !(x < W && y < H);
    e.addr = e.oob ? '0 : ADDRW'(y * W + x);
    e.data = COLRW'(c);
    sb.push_back(e);
  endtask

  task automatic push_clear(input int n, input int c);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.oob  = 1'b0;
      e.addr = ADDRW'(i);
      e.data = COLRW'(c);
      sb.push_back(e);
    end
  endtask

  task automatic wait_ready(input int lim);
    int n;
    n = 0;
    @(negedge clk);
    while (px_ready !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (px_ready !== 1'b1) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Called just after a posedge; returns just after the accepting posedge
  task automatic send_px(input int x, input int y, input int c);
    px_x     = CORDW'(x);
    px_y     = CORDW'(y);
    px_colr  = COLRW'(c);
    px_valid = 1'b1;
    wait_ready(NPIX + 50);
    @(posedge clk);
    push_px(x, y, c);
    #1 px_valid = 1'b0;
  endtask

  // Runs one full clear; dup_at>0 pulses clear again during that busy cycle
  task automatic run_clear(input int c, input int dup_at);
    clear      = 1'b1;
    clear_colr = COLRW'(c);
    @(negedge clk);
    check("clr_req_ready", {31'd0, px_ready}, 32'd0);
    @(posedge clk);
    push_clear(NPIX, c);
    #1 clear = 1'b0;
    for (int k = 1; k <= NPIX; k++) begin
      @(negedge clk);
      check("clr_busy_ready", {30'd0, busy, px_ready}, 32'b10);
      if (dup_at > 0 && k == dup_at) begin
        clear      = 1'b1;
        clear_colr = ~COLRW'(c);
      end else begin
        clear = 1'b0;
      end
    end
    @(negedge clk);
    check("clr_end_busy_ready", {30'd0, busy, px_ready}, 32'b01);
  endtask

  initial begin
    // Reset held three cycles
    repeat (3) @(negedge clk);
    check("rst_out", {29'd0, bram_we, busy, px_oob},  32'd0);
    check("rst_addr", 32'(bram_addr), 32'd0);
    check("rst_data", 32'(bram_data), 32'd0);
    check("rst_ready", {31'd0, px_ready}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_ready", {31'd0, px_ready}, 32'd1);

    // Single pixel with exact latency
    @(posedge clk);
    #1;
    send_px(5, 2, 4'hA);
    @(negedge clk);
    check("px_we", {31'd0, bram_we}, 32'd1);
    check("px_addr", 32'(bram_addr), 32'd325);
    check("px_data", 32'(bram_data), 32'hA);
    @(negedge clk);
    check("px_we_drop", {31'd0, bram_we}, 32'd0);
    @(posedge clk);
    #1;

    // Corners and out-of-bounds, back to back
    send_px(159, 119, 4'h5);
    send_px(0, 0, 4'h7);
    send_px(160, 0, 4'h1);
    @(negedge clk);
    check("oob_pulse", {30'd0, px_oob, bram_we}, 32'b10);
    @(posedge clk);
    #1;
    send_px(0, 120, 4'h2);
    @(negedge clk);
    check("oob_pulse2", {30'd0, px_oob, bram_we}, 32'b10);
    @(negedge clk);
    check("oob_end", {30'd0, px_oob, bram_we}, 32'b00);
    @(posedge clk);
    #1;
    for (int i = 0; i < 24; i++)
      send_px($urandom_range(0, 175), $urandom_range(0, 130), $urandom_range(0, 15));
    repeat (2) @(posedge clk);
    #1;

    // Full clear
    run_clear(4'h3, 0);
    @(posedge clk);
    #1;

    // Clear and pixel offered together, plus a clear during CLEAR
    px_x     = CORDW'(10);
    px_y     = CORDW'(10);
    px_colr  = 4'hC;
    px_valid = 1'b1;
    run_clear(4'h6, 5);
    @(posedge clk);
    push_px(10, 10, 4'hC);
    #1 px_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("no_queued_clear", {31'd0, busy}, 32'd0);
    check("no_queued_ready", {31'd0, px_ready}, 32'd1);

    // Reset in the middle of a clear
    @(posedge clk);
    #1;
    clear      = 1'b1;
    clear_colr = 4'h9;
    @(posedge clk);
    push_clear(101, 4'h9);
    #1 clear = 1'b0;
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_addr", 32'(bram_addr), 32'd100);
    check("abort_rst_ready", {31'd0, px_ready}, 32'd0);
    @(negedge clk);
    check("abort_we_busy", {30'd0, bram_we, busy}, 32'b00);
    rst = 1'b0;
    #1;
    check("abort_ready", {31'd0, px_ready}, 32'd1);
    @(posedge clk);
    #1;
    send_px(1, 1, 4'h4);
    repeat (3) @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
